button_debounce_multi: RTL and testbench

Multi-channel, parameterised push-button conditioner for the GPU test board's user inputs. It synchronises N raw button pins, debounces each one independently with a stable-time counter, and presents a clean per-channel pressed level. It also emits single-cycle press, release and long-press event strobes, plus optional auto-repeat strobes. It sits between the board pins and the control/register logic, replacing single-button debounce instances.

---
 rtl/button_debounce_multi_if.sv | 22 ++
 rtl/button_debounce_multi.sv | 142 ++++++++++++++
 tb/tb_button_debounce_multi.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_debounce_multi_if.sv
// Pin-side and event-side signals of the multi-channel button conditioner.
// The slave modport is the conditioner; master is whatever drives the pins and consumes events.
interface button_debounce_multi_if #(
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS-1:0] btn_in;
  logic [CHANNELS-1:0] db_out;
  logic [CHANNELS-1:0] press_pulse;
  logic [CHANNELS-1:0] release_pulse;
  logic [CHANNELS-1:0] long_pulse;
  logic [CHANNELS-1:0] repeat_pulse;

  modport master (
    output btn_in,
    input  db_out, press_pulse, release_pulse, long_pulse, repeat_pulse
  );

  modport slave (
    input  btn_in,
    output db_out, press_pulse, release_pulse, long_pulse, repeat_pulse
  );
endinterface

// File: rtl/button_debounce_multi.sv
// N-channel button conditioner: synchronise, debounce, press/release/long-press strobes.
// Auto-repeat strobes are built only when DEBOUNCE_REPEAT_EN is defined.
module button_debounce_multi #(
  parameter int unsigned         CHANNELS      = 4,
  parameter int unsigned         STABLE_CYCLES = 1024,
  parameter logic [CHANNELS-1:0] POLARITY      = '1,
  parameter int unsigned         TICK_DIV      = 38000,
  parameter int unsigned         LONG_TICKS    = 500,
  parameter int unsigned         REPEAT_TICKS  = 100
) (
  input  logic                   clk,
  input  logic                   n_reset,
  button_debounce_multi_if.slave bus
);
  localparam int unsigned CNT_W    = $clog2(STABLE_CYCLES);
  localparam int unsigned HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam int unsigned PRE_W    = $clog2(TICK_DIV);

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} state_t;

  logic [CHANNELS-1:0] s1_q, s2_q, lvl;
  logic [CHANNELS-1:0] db_q, db_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] rel_q, rel_d;
  logic [CHANNELS-1:0] long_q, long_d;
  logic [CNT_W-1:0]    cnt_q  [CHANNELS];
  logic [CNT_W-1:0]    cnt_d  [CHANNELS];
  logic [HOLD_W-1:0]   hold_q [CHANNELS];
  logic [HOLD_W-1:0]   hold_d [CHANNELS];
  state_t              st_q   [CHANNELS];
  state_t              st_d   [CHANNELS];
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                tick;
`ifdef DEBOUNCE_REPEAT_EN
  logic [CHANNELS-1:0] rep_q, rep_d;
`endif

  assign lvl = s2_q ~^ POLARITY;

  always_comb begin
    tick    = (pre_q == PRE_W'(TICK_DIV - 1));
    pre_d   = tick ? '0 : pre_q + 1'b1;
    db_d    = db_q;
    press_d = '0;
    rel_d   = '0;
    long_d  = '0;
`ifdef DEBOUNCE_REPEAT_EN
    rep_d   = '0;
`endif
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_d[i]  = '0;
      hold_d[i] = hold_q[i];
      st_d[i]   = st_q[i];
      if (lvl[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_W'(STABLE_CYCLES - 1)) begin
          db_d[i]    = lvl[i];
          press_d[i] = lvl[i];
          rel_d[i]   = ~lvl[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      // FSM follows the debounce decision of this same edge, so a release always beats a pending long-press.
      if (press_d[i]) begin
        st_d[i]   = ST_HELD;
        hold_d[i] = '0;
      end else if (rel_d[i] || !db_q[i]) begin
        st_d[i]   = ST_IDLE;
        hold_d[i] = '0;
      end else if (tick) begin
        case (st_q[i])
          ST_HELD: begin
            if (hold_q[i] == HOLD_W'(LONG_TICKS - 1)) begin
              st_d[i]   = ST_LONG;
              long_d[i] = 1'b1;
              hold_d[i] = '0;
            end else begin
              hold_d[i] = hold_q[i] + 1'b1;
            end
          end
          ST_LONG: begin
`ifdef DEBOUNCE_REPEAT_EN
            if (hold_q[i] == HOLD_W'(REPEAT_TICKS - 1)) begin
              rep_d[i]  = 1'b1;
              hold_d[i] = '0;
            end else begin
              hold_d[i] = hold_q[i] + 1'b1;
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      // Synchronisers start at the inactive pin level so the logical level starts released.
      s1_q    <= ~POLARITY;
      s2_q    <= ~POLARITY;
      db_q    <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      pre_q   <= '0;
`ifdef DEBOUNCE_REPEAT_EN
      rep_q   <= '0;
`endif
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        hold_q[i] <= '0;
        st_q[i]   <= ST_IDLE;
      end
    end else begin
      s1_q    <= bus.btn_in;
      s2_q    <= s1_q;
      db_q    <= db_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      pre_q   <= pre_d;
`ifdef DEBOUNCE_REPEAT_EN
      rep_q   <= rep_d;
`endif
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      st_q    <= st_d;
    end
  end

  assign bus.db_out        = db_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = rel_q;
  assign bus.long_pulse    = long_q;
`ifdef DEBOUNCE_REPEAT_EN
  assign bus.repeat_pulse  = rep_q;
`else
  assign bus.repeat_pulse  = '0;
`endif
endmodule

// File: tb/tb_button_debounce_multi.sv
// Bench for button_debounce_multi: window-based reference model checked every cycle,
// plus directed scenarios with hand-computed event timings.
module tb_button_debounce_multi;
  localparam int unsigned CH = 4;
  localparam int unsigned ST = 8;
  localparam int unsigned TD = 4;
  localparam int unsigned LT = 5;
  localparam int unsigned RT = 3;
  localparam logic [3:0]  POL  = 4'b1110;
  localparam logic [3:0]  IDLE = ~POL;
`ifdef DEBOUNCE_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_reset;

  button_debounce_multi_if #(.CHANNELS(CH)) bus ();

  button_debounce_multi #(
    .CHANNELS(CH), .STABLE_CYCLES(ST), .POLARITY(POL),
    .TICK_DIV(TD), .LONG_TICKS(LT), .REPEAT_TICKS(RT)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Inputs as seen by the active edge.
  logic [CH-1:0] cap_btn;
  logic          cap_rst;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    cap_btn <= bus.btn_in;
    cap_rst <= n_reset;
  end

  // Reference model: db flips when the last ST synchronised samples all disagree with it;
  // long/repeat are counted in prescaler ticks since the press / last event.
  logic [CH-1:0] pin_log [$];
  logic [CH-1:0] m_db, m_press, m_rel, m_long, m_rep;
  int            m_pre;
  int            m_phase [CH];
  int            m_ticks [CH];
  bit            m_valid = 1'b0;

  always @(negedge clk) begin
    int t;
    bit tk;
    bit dis;
    logic lv;
    if (pin_log.size() == 0)
      for (int i = 0; i < int'(ST) + 2; i++) pin_log.push_back(IDLE);
    if (!cap_rst) begin
      pin_log.push_back(IDLE);
      m_db = '0; m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
      m_pre = 0;
      for (int c = 0; c < int'(CH); c++) begin
        m_phase[c] = 0;
        m_ticks[c] = 0;
      end
      m_valid = 1'b1;
    end else begin
      pin_log.push_back(cap_btn);
      if (pin_log.size() > 64) void'(pin_log.pop_front());
      t = pin_log.size() - 1;
      tk = (m_pre == int'(TD) - 1);
      m_pre = (m_pre + 1) % int'(TD);
      m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
      for (int c = 0; c < int'(CH); c++) begin
        dis = 1'b1;
        for (int j = 0; j < int'(ST); j++) begin
          lv = pin_log[t - 2 - j][c] ~^ POL[c];
          if (lv == m_db[c]) dis = 1'b0;
        end
        if (dis) begin
          m_db[c] = ~m_db[c];
          if (m_db[c]) m_press[c] = 1'b1;
          else         m_rel[c]   = 1'b1;
        end
        if (m_press[c]) begin
          m_phase[c] = 1;
          m_ticks[c] = 0;
        end else if (!m_db[c]) begin
          m_phase[c] = 0;
        end else if (tk && m_phase[c] == 1) begin
          m_ticks[c]++;
          if (m_ticks[c] == int'(LT)) begin
            m_long[c]  = 1'b1;
            m_phase[c] = 2;
            m_ticks[c] = 0;
          end
        end else if (tk && m_phase[c] == 2 && REP_EN) begin
          m_ticks[c]++;
          if (m_ticks[c] == int'(RT)) begin
            m_rep[c]   = 1'b1;
            m_ticks[c] = 0;
          end
        end
      end
    end
    if (m_valid) begin
      check("db_out",        int'(bus.db_out),        int'(m_db));
      check("press_pulse",   int'(bus.press_pulse),   int'(m_press));
      check("release_pulse", int'(bus.release_pulse), int'(m_rel));
      check("long_pulse",    int'(bus.long_pulse),    int'(m_long));
      check("repeat_pulse",  int'(bus.repeat_pulse),  int'(m_rep));
    end
  end

  // Observed event counts and timestamps from the DUT.
  int press_n [CH];
  int rel_n   [CH];
  int long_n  [CH];
  int rep_n   [CH];
  int press_t [CH];
  int long_t  [CH];
  int last_t  [CH];
  int gap3    [$];
  always @(negedge clk) begin
    for (int c = 0; c < int'(CH); c++) begin
      if (bus.press_pulse[c])   begin press_n[c]++; press_t[c] = cyc; end
      if (bus.release_pulse[c]) rel_n[c]++;
      if (bus.long_pulse[c])    begin long_n[c]++; long_t[c] = cyc; last_t[c] = cyc; end
      if (bus.repeat_pulse[c]) begin
        rep_n[c]++;
        if (c == 3) gap3.push_back(cyc - last_t[c]);
        last_t[c] = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic int evt_cnt(input int kind, input int c);
    case (kind)
      0:       return press_n[c];
      1:       return rel_n[c];
      2:       return long_n[c];
      default: return rep_n[c];
    endcase
  endfunction

  task automatic wait_evt(input int kind, input int c, input int limit, input string name);
    int n0 = evt_cnt(kind, c);
    bit found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      step(1);
      if (evt_cnt(kind, c) != n0) found = 1'b1;
    end
    check(name, int'(found), 1);
  endtask

  initial begin
    int k, pt, d, l0, r0, q0, rel1, rel2, lng1;
    n_reset    = 1'b0;
    bus.btn_in = IDLE;
    step(3);
    n_reset = 1'b1;
    step(50);
    check("idle db_out", int'(bus.db_out), 0);
    check("idle strobe count",
          press_n[0] + press_n[1] + press_n[2] + press_n[3] + rel_n[0] + rel_n[1] + rel_n[2] + rel_n[3] +
          long_n[0] + long_n[1] + long_n[2] + long_n[3], 0);

    // ch1 active-high press
    k = cyc + 1;
    bus.btn_in[1] = 1'b1;
    wait_evt(0, 1, 20, "ch1 press seen");
    check("ch1 press latency", press_t[1], k + 9);
    check("ch1 db_out", int'(bus.db_out[1]), 1);
    step(1);
    check("ch1 press width", int'(bus.press_pulse[1]), 0);
    bus.btn_in[1] = 1'b0;
    step(15);

    // ch0 active-low press
    k = cyc + 1;
    bus.btn_in[0] = 1'b0;
    wait_evt(0, 0, 20, "ch0 press seen");
    check("ch0 press latency", press_t[0], k + 9);
    bus.btn_in[0] = 1'b1;
    step(15);

    // ch2 bounce: 7 high / 1 low, then steady high
    q0 = press_n[2];
    for (int r = 0; r < 8; r++) begin
      bus.btn_in[2] = 1'b1; step(7);
      bus.btn_in[2] = 1'b0; step(1);
    end
    check("ch2 no press during bounce", press_n[2] - q0, 0);
    k = cyc + 1;
    bus.btn_in[2] = 1'b1;
    wait_evt(0, 2, 20, "ch2 press seen");
    check("ch2 press latency", press_t[2], k + 9);
    bus.btn_in[2] = 1'b0;
    step(15);

    // ch3 long press (and repeats when built)
    l0 = long_n[3];
    r0 = rep_n[3];
    bus.btn_in[3] = 1'b1;
    wait_evt(0, 3, 20, "ch3 press seen");
    pt = press_t[3];
    wait_evt(2, 3, 30, "ch3 long seen");
    d = long_t[3] - pt;
    check("ch3 long latency in 16..20", int'(d >= 16 && d <= 20), 1);
    step(50);
    bus.btn_in[3] = 1'b0;
    step(15);
    check("ch3 long once", long_n[3] - l0, 1);
`ifdef DEBOUNCE_REPEAT_EN
    check("ch3 repeats >= 2", int'(rep_n[3] - r0 >= 2), 1);
    foreach (gap3[i]) check("ch3 repeat spacing", gap3[i], 12);
`else
    check("ch3 no repeats", rep_n[3] - r0, 0);
`endif

    // ch1+ch2 together, ch1 released while HELD
    rel1 = rel_n[1]; rel2 = rel_n[2]; lng1 = long_n[1];
    k = cyc + 1;
    bus.btn_in[1] = 1'b1;
    bus.btn_in[2] = 1'b1;
    wait_evt(0, 1, 20, "ch1 dual press seen");
    check("ch1 dual press latency", press_t[1], k + 9);
    check("ch2 dual press latency", press_t[2], k + 9);
    step(4);
    bus.btn_in[1] = 1'b0;
    step(30);
    check("ch1 release once", rel_n[1] - rel1, 1);
    check("ch2 no release", rel_n[2] - rel2, 0);
    check("ch1 no long", long_n[1] - lng1, 0);
    bus.btn_in[2] = 1'b0;
    step(15);

    // reset while ch1 in LONG
    bus.btn_in[1] = 1'b1;
    wait_evt(2, 1, 40, "ch1 long before reset");
    step(3);
    rel1 = rel_n[1];
    n_reset = 1'b0;
    step(3);
    check("reset outputs zero",
          int'({bus.db_out, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse}), 0);
    n_reset = 1'b1;
    k = cyc + 1;
    wait_evt(0, 1, 20, "ch1 press after reset");
    check("ch1 press after reset latency", press_t[1], k + 9);
    check("ch1 no release across reset", rel_n[1] - rel1, 0);
    bus.btn_in[1] = 1'b0;
    step(15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
